// File: rtl/uart_cmd_sender.sv
// UART command sender: serialises register-file / ALU command packets onto TX_SER
// with optional parity, a programmable bit period and one idle bit between bytes.
module uart_cmd_sender #(
   parameter int unsigned Data_width     = 8,
   parameter int unsigned Prescale_width = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      CMD_valid,
   input  logic [1:0]                CMD_type,
   input  logic [3:0]                CMD_addr,
   input  logic [Data_width-1:0]     CMD_A,
   input  logic [Data_width-1:0]     CMD_B,
   input  logic [3:0]                CMD_fun,
   input  logic [Prescale_width-1:0] prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   output logic                      CMD_ready,
   output logic                      TX_SER,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int unsigned BIT_W = (Data_width > 1) ? $clog2(Data_width) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

   state_t                    state_q, state_d;
   logic [Prescale_width-1:0] presc_q, presc_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [1:0]                byte_q, byte_d;
   logic                      tx_q, tx_d;
   logic                      ready_q, ready_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic [1:0]                type_q;
   logic [3:0]                addr_q;
   logic [Data_width-1:0]     a_q, b_q;
   logic [3:0]                fun_q;
   logic [Prescale_width-1:0] scale_q;
   logic                      par_en_q, par_typ_q;

   logic                      accept;
   logic                      period_end;
   logic [Prescale_width-1:0] last_cnt;
   logic [1:0]                last_byte;
   logic [Data_width-1:0]     cur_byte;
   logic [BIT_W-1:0]          next_bit;
   logic                      par_bit;

   assign accept     = (state_q == IDLE) && ready_q && CMD_valid;
   // A captured prescale of 0 behaves like 1 cycle per bit.
   assign last_cnt   = (scale_q == '0) ? '0 : scale_q - Prescale_width'(1);
   assign period_end = (presc_q == last_cnt);
   assign next_bit   = bit_q + BIT_W'(1);
   assign par_bit    = (^cur_byte) ^ par_typ_q;

   always_comb begin
      last_byte = 2'd1;
      cur_byte  = '0;
      case (type_q)
         2'b00: last_byte = 2'd2;
         2'b10: last_byte = 2'd3;
         default: last_byte = 2'd1;
      endcase
      case ({type_q, byte_q})
         4'b00_00: cur_byte = Data_width'(8'hAA);
         4'b00_01: cur_byte = Data_width'(addr_q);
         4'b00_10: cur_byte = a_q;
         4'b01_00: cur_byte = Data_width'(8'hBB);
         4'b01_01: cur_byte = Data_width'(addr_q);
         4'b10_00: cur_byte = Data_width'(8'hCC);
         4'b10_01: cur_byte = a_q;
         4'b10_10: cur_byte = b_q;
         4'b10_11: cur_byte = Data_width'(fun_q);
         4'b11_00: cur_byte = Data_width'(8'hDD);
         4'b11_01: cur_byte = Data_width'(fun_q);
         default:  cur_byte = '0;
      endcase
   end

   // Next-state and next-output logic; tx_d is the level for the coming cycle.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      if (state_q != IDLE)
         presc_d = period_end ? '0 : presc_q + Prescale_width'(1);
      case (state_q)
         IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            if (accept) begin
               state_d = START;
               tx_d    = 1'b0;
               ready_d = 1'b0;
               presc_d = '0;
               bit_d   = '0;
               byte_d  = '0;
            end
         end
         START: if (period_end) begin
            state_d = DATA;
            bit_d   = '0;
            tx_d    = cur_byte[0];
         end
         DATA: if (period_end) begin
            if (bit_q == BIT_W'(Data_width - 1)) begin
               bit_d   = '0;
               state_d = par_en_q ? PARITY : STOP;
               tx_d    = par_en_q ? par_bit : 1'b1;
            end else begin
               bit_d = next_bit;
               tx_d  = cur_byte[next_bit];
            end
         end
         PARITY: if (period_end) begin
            state_d = STOP;
            tx_d    = 1'b1;
         end
         STOP: if (period_end) begin
            tx_d = 1'b1;
            if (byte_q == last_byte) begin
               state_d = IDLE;
               byte_d  = '0;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               state_d = GAP;
               byte_d  = byte_q + 2'd1;
            end
         end
         GAP: if (period_end) begin
            state_d = START;
            tx_d    = 1'b0;
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
      endcase
      busy_d = ~ready_d;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         presc_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Command capture; held stable for the whole transmission.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         type_q    <= '0;
         addr_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         fun_q     <= '0;
         scale_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (accept) begin
         type_q    <= CMD_type;
         addr_q    <= CMD_addr;
         a_q       <= CMD_A;
         b_q       <= CMD_B;
         fun_q     <= CMD_fun;
         scale_q   <= prescale;
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
      end
   end

   assign TX_SER     = tx_q;
   assign CMD_ready  = ready_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Directed bench for uart_cmd_sender: table of commands checked cycle-by-cycle
// against a bit-level line model, plus back-to-back and reset corner sequences.
module tb_uart_cmd_sender;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CMD_valid;
   logic [1:0] CMD_type;
   logic [3:0] CMD_addr;
   logic [7:0] CMD_A, CMD_B;
   logic [3:0] CMD_fun;
   logic [5:0] prescale;
   logic       PAR_EN, PAR_TYP;
   logic       CMD_ready, TX_SER, busy, frame_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] typ;
      logic [3:0] addr;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] fun;
      logic [5:0] ps;
      logic       pen;
      logic       ptyp;
      bit         mid_pulse;
      int         exp_done;
   } vec_t;

   vec_t vecs[7];
   bit   exp_q[$];

   uart_cmd_sender #(.Data_width(8), .Prescale_width(6)) dut (
      .CLK(CLK), .RST(RST), .CMD_valid(CMD_valid), .CMD_type(CMD_type),
      .CMD_addr(CMD_addr), .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_fun(CMD_fun),
      .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .CMD_ready(CMD_ready), .TX_SER(TX_SER), .busy(busy), .frame_done(frame_done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected line level for every cycle after the accepting edge.
   task automatic build(input vec_t v);
      logic [7:0] bs[$];
      logic [7:0] cur;
      int p;
      bit pb;
      exp_q.delete();
      p = (v.ps == 0) ? 1 : int'(v.ps);
      case (v.typ)
         2'b00: begin bs.push_back(8'hAA); bs.push_back({4'h0, v.addr}); bs.push_back(v.a); end
         2'b01: begin bs.push_back(8'hBB); bs.push_back({4'h0, v.addr}); end
         2'b10: begin bs.push_back(8'hCC); bs.push_back(v.a); bs.push_back(v.b);
                      bs.push_back({4'h0, v.fun}); end
         default: begin bs.push_back(8'hDD); bs.push_back({4'h0, v.fun}); end
      endcase
      for (int i = 0; i < bs.size(); i++) begin
         cur = bs[i];
         pb  = (^cur) ^ v.ptyp;
         for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
         for (int b = 0; b < 8; b++)
            for (int k = 0; k < p; k++) exp_q.push_back(cur[b]);
         if (v.pen)
            for (int k = 0; k < p; k++) exp_q.push_back(pb);
         for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
         if (i < bs.size() - 1)
            for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
      end
   endtask

   task automatic drive(input vec_t v);
      CMD_type = v.typ; CMD_addr = v.addr; CMD_A = v.a; CMD_B = v.b;
      CMD_fun = v.fun; prescale = v.ps; PAR_EN = v.pen; PAR_TYP = v.ptyp;
   endtask

   // Called just after a falling edge; accepts on the next rising edge.
   task automatic run_cmd(input vec_t v, input string tag);
      int len, tx_errs, st_errs, done_at, done_cnt, first_err;
      bit exp_tx, exp_busy;
      build(v);
      len = exp_q.size();
      tx_errs = 0; st_errs = 0; done_at = 0; done_cnt = 0; first_err = 0;
      drive(v);
      CMD_valid = 1'b1;
      check({tag, " ready_before_accept"}, int'(CMD_ready), 1);
      @(posedge CLK);
      #1 CMD_valid = 1'b0;
      for (int c = 1; c <= len + 12; c++) begin
         @(negedge CLK);
         if (v.mid_pulse && c == 40) begin
            CMD_valid = 1'b1; CMD_type = 2'b11; CMD_A = ~v.a; prescale = 6'd1;
            PAR_EN = ~v.pen; PAR_TYP = ~v.ptyp; CMD_fun = 4'hF;
         end
         if (v.mid_pulse && c == 41) CMD_valid = 1'b0;
         exp_tx   = (c <= len) ? exp_q[c-1] : 1'b1;
         exp_busy = (c <= len);
         if (TX_SER !== exp_tx) begin
            tx_errs++;
            if (first_err == 0) first_err = c;
         end
         if (busy !== exp_busy || CMD_ready !== !exp_busy) st_errs++;
         if (frame_done === 1'b1) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
      end
      check({tag, " tx_trace_errs"}, tx_errs, 0);
      if (tx_errs != 0) $display("  %s first line error at cycle %0d", tag, first_err);
      check({tag, " ready_busy_errs"}, st_errs, 0);
      check({tag, " done_cycle"}, done_at, v.exp_done);
      check({tag, " done_pulses"}, done_cnt, 1);
   endtask

   initial begin
      int done_at, errs;
      vec_t v;
      vecs[0] = '{2'b00, 4'h5, 8'h3C, 8'h00, 4'h0, 6'd8,  1'b0, 1'b0, 1'b0, 257};
      vecs[1] = '{2'b01, 4'h2, 8'h00, 8'h00, 4'h0, 6'd16, 1'b1, 1'b0, 1'b0, 369};
      vecs[2] = '{2'b10, 4'h0, 8'h10, 8'h03, 4'h0, 6'd8,  1'b1, 1'b1, 1'b1, 377};
      vecs[3] = '{2'b01, 4'h9, 8'h00, 8'h00, 4'h0, 6'd0,  1'b0, 1'b0, 1'b0, 22};
      vecs[4] = '{2'b11, 4'h0, 8'h00, 8'h00, 4'h7, 6'd3,  1'b1, 1'b0, 1'b0, 70};
      vecs[5] = '{2'b00, 4'hF, 8'hFF, 8'h00, 4'h0, 6'd1,  1'b1, 1'b1, 1'b0, 36};
      vecs[6] = '{2'b01, 4'hA, 8'h00, 8'h00, 4'h0, 6'd63, 1'b0, 1'b0, 1'b0, 1324};

      CMD_valid = 1'b0;
      drive(vecs[0]);
      RST = 1'b1;
      #1 RST = 1'b0;
      #1;
      check("reset tx", int'(TX_SER), 1);
      check("reset ready", int'(CMD_ready), 1);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(frame_done), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      run_cmd(vecs[3], "first_edge_after_reset");

      for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back: CMD_valid held through frame_done.
      v = '{2'b11, 4'h0, 8'h00, 8'h00, 4'h1, 6'd4, 1'b0, 1'b0, 1'b0, 85};
      drive(v);
      CMD_valid = 1'b1;
      @(posedge CLK);
      done_at = 0;
      for (int c = 1; c <= 200 && done_at == 0; c++) begin
         @(negedge CLK);
         if (frame_done === 1'b1) done_at = c;
      end
      check("b2b first done_cycle", done_at, 85);
      check("b2b ready_in_done", int'(CMD_ready), 1);
      check("b2b busy_in_done", int'(busy), 0);
      @(posedge CLK);
      #1 CMD_valid = 1'b0;
      @(negedge CLK);
      check("b2b tx_low_after_accept", int'(TX_SER), 0);
      check("b2b busy_after_accept", int'(busy), 1);
      done_at = 0;
      for (int c = 2; c <= 200 && done_at == 0; c++) begin
         @(negedge CLK);
         if (frame_done === 1'b1) done_at = c;
      end
      check("b2b second done_cycle", done_at, 85);
      @(negedge CLK);

      // Reset in the middle of the address byte's data bits.
      v = '{2'b00, 4'h0, 8'h5A, 8'h00, 4'h0, 6'd4, 1'b0, 1'b0, 1'b0, 0};
      drive(v);
      CMD_valid = 1'b1;
      @(posedge CLK);
      #1 CMD_valid = 1'b0;
      for (int c = 1; c <= 55; c++) @(negedge CLK);
      check("pre_reset tx", int'(TX_SER), 0);
      check("pre_reset busy", int'(busy), 1);
      #2 RST = 1'b0;
      #1;
      check("mid_reset tx", int'(TX_SER), 1);
      check("mid_reset ready", int'(CMD_ready), 1);
      check("mid_reset busy", int'(busy), 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      errs = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (TX_SER !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || CMD_ready !== 1'b1)
            errs++;
      end
      check("post_reset idle_errs", errs, 0);
      run_cmd(vecs[0], "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
